cp0_exc_ctrl: RTL and testbench

- Parametrised coprocessor-0 exception/interrupt controller for the P7 MIPS pipeline.
- Consumes the resolved M-stage exception code, the victim PC, the branch-delay flag and HW_INT_NUM hardware interrupt lines.
- Holds SR, Cause, EPC, PRId and a new saturating exception counter. Raises the pipeline flush/redirect request and supplies EPC for eret.
- Generalises the fixed 6-line design: configurable interrupt count and PRId, an exception tally register, and defined same-cycle priority between request, eret and mtc0.

---
 rtl/cp0_exc_ctrl_if.sv | 27 ++
 rtl/cp0_exc_ctrl.sv | 118 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// Bus bundle between the M stage and the CP0 exception controller.
// The master drives pipeline state; the slave returns read data and the redirect request.
interface cp0_exc_ctrl_if #(
  parameter int unsigned HW_INT_NUM = 6
);
  logic                  en;
  logic [4:0]            CP0Add;
  logic [31:0]           CP0In;
  logic [31:0]           CP0Out;
  logic [31:0]           VPC;
  logic                  BDIn;
  logic [4:0]            ExcCodeIn;
  logic [HW_INT_NUM-1:0] HWInt;
  logic                  EXLClr;
  logic [31:0]           EPCOut;
  logic                  Req;

  modport master (
    output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: SR, Cause, EPC, PRId and a saturating
// exception counter, plus the combinational flush/redirect request.
module cp0_exc_ctrl #(
  parameter int unsigned HW_INT_NUM = 6,
  parameter logic [31:0] PRID       = 32'h0000_7007,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic           clk,
  input logic           reset,
  cp0_exc_ctrl_if.slave bus
);

  localparam logic [4:0] AddrSr     = 5'd12;
  localparam logic [4:0] AddrCause  = 5'd13;
  localparam logic [4:0] AddrEpc    = 5'd14;
  localparam logic [4:0] AddrPrid   = 5'd15;
  localparam logic [4:0] AddrExcCnt = 5'd16;

  logic [HW_INT_NUM-1:0] im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic [HW_INT_NUM-1:0] ip_q, ip_d;
  logic [4:0]            exc_code_q, exc_code_d;
  logic [31:0]           epc_q, epc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic        int_req, exc_req, req;
  logic [31:0] sr_rd, cause_rd;

  assign int_req = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (bus.ExcCodeIn != 5'd0) & ~exl_q;
  assign req     = ~reset & (int_req | exc_req);
  assign bus.Req = req;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    cnt_d      = cnt_q;
    ip_d       = bus.HWInt;
    if (req) begin
      // Taking the exception discards any same-cycle mtc0.
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : bus.ExcCodeIn;
      bd_d       = bus.BDIn;
      epc_d      = (bus.BDIn ? bus.VPC - 32'd4 : bus.VPC) & ~32'd3;
      cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end else begin
      if (bus.en) begin
        case (bus.CP0Add)
          AddrSr: begin
            im_d  = bus.CP0In[10 +: HW_INT_NUM];
            exl_d = bus.CP0In[1];
            ie_d  = bus.CP0In[0];
          end
          AddrEpc:    epc_d = {bus.CP0In[31:2], 2'b00};
          AddrExcCnt: cnt_d = bus.CP0In[CNT_WIDTH-1:0];
          default:    ;
        endcase
      end
      // eret clears EXL even over a same-cycle SR write.
      if (bus.EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      cnt_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    sr_rd                   = 32'd0;
    sr_rd[10 +: HW_INT_NUM] = im_q;
    sr_rd[1]                = exl_q;
    sr_rd[0]                = ie_q;
    cause_rd                   = 32'd0;
    cause_rd[31]               = bd_q;
    cause_rd[10 +: HW_INT_NUM] = ip_q;
    cause_rd[6:2]              = exc_code_q;
  end

  always_comb begin
    case (bus.CP0Add)
      AddrSr:     bus.CP0Out = sr_rd;
      AddrCause:  bus.CP0Out = cause_rd;
      AddrEpc:    bus.CP0Out = epc_q;
      AddrPrid:   bus.CP0Out = PRID;
      AddrExcCnt: bus.CP0Out = 32'(cnt_q);
      default:    bus.CP0Out = 32'd0;
    endcase
  end

  assign bus.EPCOut = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench: default-parameter instance plus a narrow one (2 interrupt lines,
// 2-bit counter) for field masking and counter saturation.
module tb_cp0_exc_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl_if #(.HW_INT_NUM(6)) bus_a ();
  cp0_exc_ctrl_if #(.HW_INT_NUM(2)) bus_b ();

  cp0_exc_ctrl #(
    .HW_INT_NUM(6),
    .PRID      (32'h0000_7007),
    .CNT_WIDTH (32)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  cp0_exc_ctrl #(
    .HW_INT_NUM(2),
    .PRID      (32'h0000_7007),
    .CNT_WIDTH (2)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  task automatic rd_a(input logic [4:0] addr, output logic [31:0] val);
    @(negedge clk);
    bus_a.CP0Add = addr;
    #1;
    val = bus_a.CP0Out;
  endtask

  task automatic rd_b(input logic [4:0] addr, output logic [31:0] val);
    @(negedge clk);
    bus_b.CP0Add = addr;
    #1;
    val = bus_b.CP0Out;
  endtask

  task automatic wr_b(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_b.en     = 1'b1;
    bus_b.CP0Add = addr;
    bus_b.CP0In  = data;
    @(negedge clk);
    bus_b.en     = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_rd [5];
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0000_7007, 32'h0};
    @(negedge clk);
    reset           = 1'b1;
    bus_a.ExcCodeIn = 5'd10;
    bus_b.ExcCodeIn = 5'd10;
    #1;
    n_cmp++;
    if (bus_a.Req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req_a: got %b want 0", bus_a.Req);
    end
    n_cmp++;
    if (bus_b.Req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req_b: got %b want 0", bus_b.Req);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus_a.Req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req_a2: got %b want 0", bus_a.Req);
    end
    @(negedge clk);
    reset           = 1'b0;
    bus_a.ExcCodeIn = 5'd0;
    bus_b.ExcCodeIn = 5'd0;
    for (int i = 0; i < 5; i++) begin
      rd_a(5'(12 + i), v);
      n_cmp++;
      if (v !== exp_rd[i]) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h want %h", 12 + i, v, exp_rd[i]);
      end
    end
    n_cmp++;
    if (bus_a.EPCOut !== 32'h0) begin
      n_err++;
      $display("FAIL reset_epcout: got %h want 0", bus_a.EPCOut);
    end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    @(negedge clk);
    bus_a.ExcCodeIn = 5'd12;
    bus_a.VPC       = 32'h3010;
    bus_a.BDIn      = 1'b0;
    #1;
    n_cmp++;
    if (bus_a.Req !== 1'b1) begin
      n_err++;
      $display("FAIL exc_req: got %b want 1", bus_a.Req);
    end
    @(negedge clk);
    bus_a.ExcCodeIn = 5'd0;
    rd_a(5'd13, v);
    n_cmp++;
    if (v !== 32'h0000_0030) begin
      n_err++;
      $display("FAIL exc_cause: got %h want 00000030", v);
    end
    rd_a(5'd14, v);
    n_cmp++;
    if (v !== 32'h3010 || bus_a.EPCOut !== 32'h3010) begin
      n_err++;
      $display("FAIL exc_epc: got %h/%h want 00003010", v, bus_a.EPCOut);
    end
    rd_a(5'd12, v);
    n_cmp++;
    if (v !== 32'h0000_0002) begin
      n_err++;
      $display("FAIL exc_sr: got %h want 00000002", v);
    end
    rd_a(5'd16, v);
    n_cmp++;
    if (v !== 32'd1) begin
      n_err++;
      $display("FAIL exc_cnt: got %h want 1", v);
    end
    @(negedge clk);
    bus_a.ExcCodeIn = 5'd4;
    #1;
    n_cmp++;
    if (bus_a.Req !== 1'b0) begin
      n_err++;
      $display("FAIL exc_masked_by_exl: got %b want 0", bus_a.Req);
    end
    @(negedge clk);
    bus_a.ExcCodeIn = 5'd0;
    rd_a(5'd16, v);
    n_cmp++;
    if (v !== 32'd1) begin
      n_err++;
      $display("FAIL exc_cnt_hold: got %h want 1", v);
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    @(negedge clk);
    bus_a.en     = 1'b1;
    bus_a.CP0Add = 5'd12;
    bus_a.CP0In  = 32'h0000_0401;
    @(negedge clk);
    bus_a.en        = 1'b0;
    bus_a.HWInt     = 6'b000001;
    bus_a.ExcCodeIn = 5'd5;
    bus_a.VPC       = 32'h3024;
    bus_a.BDIn      = 1'b1;
    #1;
    n_cmp++;
    if (bus_a.Req !== 1'b1) begin
      n_err++;
      $display("FAIL int_req: got %b want 1", bus_a.Req);
    end
    @(negedge clk);
    bus_a.ExcCodeIn = 5'd0;
    bus_a.BDIn      = 1'b0;
    rd_a(5'd13, v);
    n_cmp++;
    if (v !== 32'h8000_0400) begin
      n_err++;
      $display("FAIL int_cause: got %h want 80000400", v);
    end
    rd_a(5'd14, v);
    n_cmp++;
    if (v !== 32'h3020) begin
      n_err++;
      $display("FAIL int_epc_bd: got %h want 00003020", v);
    end
    rd_a(5'd12, v);
    n_cmp++;
    if (v !== 32'h0000_0403) begin
      n_err++;
      $display("FAIL int_sr: got %h want 00000403", v);
    end
    rd_a(5'd16, v);
    n_cmp++;
    if (v !== 32'd2) begin
      n_err++;
      $display("FAIL int_cnt: got %h want 2", v);
    end
  endtask

  task automatic test_eret_sr_write();
    @(negedge clk);
    bus_a.EXLClr = 1'b1;
    bus_a.en     = 1'b1;
    bus_a.CP0Add = 5'd12;
    bus_a.CP0In  = 32'h0000_FC03;
    #1;
    n_cmp++;
    if (bus_a.Req !== 1'b0) begin
      n_err++;
      $display("FAIL eret_req_during: got %b want 0", bus_a.Req);
    end
    @(negedge clk);
    bus_a.EXLClr = 1'b0;
    bus_a.en     = 1'b0;
    #1;
    n_cmp++;
    if (bus_a.CP0Out !== 32'h0000_FC01) begin
      n_err++;
      $display("FAIL eret_sr: got %h want 0000fc01", bus_a.CP0Out);
    end
    n_cmp++;
    if (bus_a.Req !== 1'b1) begin
      n_err++;
      $display("FAIL eret_pending_int: got %b want 1", bus_a.Req);
    end
    @(negedge clk);
    bus_a.HWInt = 6'b0;
    #1;
    n_cmp++;
    if (bus_a.EPCOut !== 32'h3024) begin
      n_err++;
      $display("FAIL eret_int_epc: got %h want 00003024", bus_a.EPCOut);
    end
  endtask

  task automatic test_narrow_fields();
    logic [31:0] v;
    wr_b(5'd12, 32'hFFFF_FFFF);
    rd_b(5'd12, v);
    n_cmp++;
    if (v !== 32'h0000_0C03) begin
      n_err++;
      $display("FAIL narrow_sr: got %h want 00000c03", v);
    end
    wr_b(5'd14, 32'h3007);
    rd_b(5'd14, v);
    n_cmp++;
    if (v !== 32'h3004) begin
      n_err++;
      $display("FAIL narrow_epc_align: got %h want 00003004", v);
    end
    wr_b(5'd13, 32'hFFFF_FFFF);
    rd_b(5'd13, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL narrow_cause_ro: got %h want 0", v);
    end
    wr_b(5'd17, 32'hFFFF_FFFF);
    rd_b(5'd17, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL narrow_unmapped: got %h want 0", v);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] v;
    wr_b(5'd16, 32'hFFFF_FFFF);
    rd_b(5'd16, v);
    n_cmp++;
    if (v !== 32'd3) begin
      n_err++;
      $display("FAIL sat_load: got %h want 3", v);
    end
    wr_b(5'd12, 32'h0);
    @(negedge clk);
    bus_b.ExcCodeIn = 5'd1;
    bus_b.en        = 1'b1;
    bus_b.CP0Add    = 5'd16;
    bus_b.CP0In     = 32'h0;
    #1;
    n_cmp++;
    if (bus_b.Req !== 1'b1) begin
      n_err++;
      $display("FAIL sat_req: got %b want 1", bus_b.Req);
    end
    @(negedge clk);
    bus_b.ExcCodeIn = 5'd0;
    bus_b.en        = 1'b0;
    rd_b(5'd16, v);
    n_cmp++;
    if (v !== 32'd3) begin
      n_err++;
      $display("FAIL sat_hold: got %h want 3", v);
    end
    wr_b(5'd16, 32'h0);
    rd_b(5'd16, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL sat_clear: got %h want 0", v);
    end
    // eret, then an exception racing an mtc0: increment wins over the write.
    @(negedge clk);
    bus_b.EXLClr = 1'b1;
    @(negedge clk);
    bus_b.EXLClr    = 1'b0;
    bus_b.ExcCodeIn = 5'd8;
    bus_b.en        = 1'b1;
    bus_b.CP0Add    = 5'd16;
    bus_b.CP0In     = 32'd2;
    @(negedge clk);
    bus_b.ExcCodeIn = 5'd0;
    bus_b.en        = 1'b0;
    rd_b(5'd16, v);
    n_cmp++;
    if (v !== 32'd1) begin
      n_err++;
      $display("FAIL sat_inc_over_write: got %h want 1", v);
    end
    rd_b(5'd13, v);
    n_cmp++;
    if (v !== 32'h0000_0020) begin
      n_err++;
      $display("FAIL narrow_exc_cause: got %h want 00000020", v);
    end
  endtask

  initial begin
    reset = 1'b1;
    {bus_a.en, bus_a.BDIn, bus_a.EXLClr} = '0;
    {bus_b.en, bus_b.BDIn, bus_b.EXLClr} = '0;
    bus_a.CP0Add = 5'd0; bus_a.CP0In = 32'd0; bus_a.VPC = 32'd0;
    bus_a.ExcCodeIn = 5'd0; bus_a.HWInt = '0;
    bus_b.CP0Add = 5'd0; bus_b.CP0In = 32'd0; bus_b.VPC = 32'd0;
    bus_b.ExcCodeIn = 5'd0; bus_b.HWInt = '0;
    test_reset();
    test_exception();
    test_interrupt();
    test_eret_sr_write();
    test_narrow_fields();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
